// File: rtl/mult_desp_suma.sv
// mult_desp_suma: sequential shift-and-add unsigned multiplier built on the sumadores adder
module sumadores (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);
  logic [4:0] c;
  assign c[0] = c_in;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign c_out = c[4];
endmodule

module mult_desp_suma #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;
  state_t           state;
  logic [WIDTH-1:0] mcand, mplr, s, nxt_mplr;
  logic [WIDTH:0]   acc, nxt_acc;
  logic [CW-1:0]    cnt;
  logic             c;
  if (WIDTH == 4) begin : g_add
    sumadores u_add (.a(acc[WIDTH-1:0]), .b(mcand), .c_in(1'b0), .s(s), .c_out(c));
  end else begin : g_add
    assign {c, s} = {1'b0, acc[WIDTH-1:0]} + {1'b0, mcand};
  end
  // one shift-and-add step: add mcand into the upper half only when the multiplier LSB is set
  always_comb begin
    nxt_acc  = mplr[0] ? {1'b0, c, s[WIDTH-1:1]} : {1'b0, acc[WIDTH:1]};
    nxt_mplr = mplr[0] ? {s[0], mplr[WIDTH-1:1]} : {acc[0], mplr[WIDTH-1:1]};
  end
  assign busy = (state == ITER);
  assign done = (state == FIN);
  // control FSM and datapath registers; FIN accepts start like IDLE for back-to-back use
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            mcand <= a;
            mplr  <= b;
            acc   <= '0;
            cnt   <= '0;
            state <= ITER;
          end else begin
            state <= IDLE;
          end
        end
        ITER: begin
          acc  <= nxt_acc;
          mplr <= nxt_mplr;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            product <= {nxt_acc[WIDTH-1:0], nxt_mplr};
            state   <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_desp_suma.sv
// tb_mult_desp_suma: table, corner-case and randomized checks of the shift-and-add multiplier
module tb_mult_desp_suma;
  logic       clk = 0, rst = 1, start = 0;
  logic [3:0] a = 0, b = 0;
  logic       busy, done;
  logic [7:0] product;
  int checks = 0, errors = 0;

  mult_desp_suma #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_mult(input logic [3:0] x, input logic [3:0] y,
                         output logic [7:0] p, output int busy_cyc, output bit seen);
    @(negedge clk);
    start = 1; a = x; b = y;
    busy_cyc = 0; seen = 0; p = 'x;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      start = 0; a = 4'($urandom); b = 4'($urandom);
      if (busy && done) chk("busy_and_done", 1, 0);
      if (busy) busy_cyc++;
      if (done) begin seen = 1; p = product; end
    end
  endtask

  logic [7:0] p;
  int bc, ndone, ncomp;
  bit seen;
  logic [7:0] expq[$];

  initial begin
    tbl[0] = '{4'd0,  4'd0,  8'h00};
    tbl[1] = '{4'd15, 4'd15, 8'hE1};
    tbl[2] = '{4'd13, 4'd11, 8'h8F};
    tbl[3] = '{4'd1,  4'd15, 8'd15};
    tbl[4] = '{4'd6,  4'd7,  8'd42};
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_product", product, 0);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      do_mult(tbl[i].a, tbl[i].b, p, bc, seen);
      chk("tbl_done_seen", seen, 1);
      chk("tbl_busy_cycles", bc, 4);
      chk("tbl_product", p, tbl[i].p);
    end
    // product holds through idle and the next iteration
    @(negedge clk);
    chk("hold_idle", product, 42);
    start = 1; a = 4'd3; b = 4'd5;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("hold_iter", product, 42);
    repeat (4) @(negedge clk);
    chk("hold_next_result", product, 15);
    // start during ITER is ignored
    @(negedge clk);
    start = 1; a = 4'd6; b = 4'd7;
    @(negedge clk);
    start = 0; a = 4'd0; b = 4'd0;
    @(negedge clk);
    start = 1; a = 4'd3; b = 4'd3;
    ndone = 0; p = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 0;
      if (done) begin ndone++; p = product; end
    end
    chk("ignore_done_count", ndone, 1);
    chk("ignore_product", p, 42);
    // reset mid-iteration discards the operation
    @(negedge clk);
    start = 1; a = 4'd9; b = 4'd9;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_product", product, 0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    do_mult(4'd2, 4'd5, p, bc, seen);
    chk("after_rst_product", p, 10);
    // start held high with operands changing every cycle
    ncomp = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (busy && done) chk("bb_busy_and_done", 1, 0);
      if (done) begin
        ncomp++;
        if (expq.size() == 0) chk("bb_unexpected_done", 1, 0);
        else chk("bb_product", product, int'(expq.pop_front()));
      end
      if (i < 25) begin
        start = 1; a = 4'($urandom); b = 4'($urandom);
        if (i % 5 == 0) expq.push_back(8'(a * b));
      end else start = 0;
    end
    chk("bb_completions", ncomp, 5);
    chk("bb_queue_empty", expq.size(), 0);
    // exhaustive sweep
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        do_mult(4'(x), 4'(y), p, bc, seen);
        if (!seen) chk("sweep_timeout", 0, 1);
        else chk("sweep_product", p, x * y);
      end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
